// File: rtl/addsub_carry_select.sv
// addsub_carry_select: two-pass carry-select adder/subtractor with valid/ready handshakes.
// Optional operand capture registers are enabled by defining ADDSUB_OPERAND_REG_EN.
module addsub_carry_select #(
    parameter int BLOCK      = 128,
    parameter int NUM_BLOCKS = 25
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BLOCK*NUM_BLOCKS-1:0]   a,
    input  logic [BLOCK*NUM_BLOCKS-1:0]   b,
    input  logic                          sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BLOCK*NUM_BLOCKS-1:0]   c,
    output logic                          carry_out
);
    localparam int W = BLOCK * NUM_BLOCKS;

    typedef enum logic [2:0] {IDLE, S0, S1, SEL, HOLD} state_t;

    state_t         state, state_nx;
    logic           sub_q;
    logic [BLOCK:0] s0 [NUM_BLOCKS];
    logic [BLOCK:0] s1 [NUM_BLOCKS];
    logic [W-1:0]   a_op, b_op, b_x, sum;
    logic [BLOCK:0] sel;
    logic           cy;

    assign in_ready = (state == IDLE);
    assign b_x      = sub_q ? ~b_op : b_op;

`ifdef ADDSUB_OPERAND_REG_EN
    logic [W-1:0] a_q, b_q;

    // capture operands at acceptance so the requester is free to change them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (in_valid && in_ready) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign a_op = a_q;
    assign b_op = b_q;
`else
    assign a_op = a;
    assign b_op = b;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state decode: fixed three-cycle compute, then wait for the consumer
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? S0 : IDLE;
            S0:      state_nx = S1;
            S1:      state_nx = SEL;
            SEL:     state_nx = HOLD;
            HOLD:    state_nx = out_ready ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // ripple select: each slice picks its precomputed sum by the incoming carry
    always_comb begin
        cy  = sub_q;
        sum = '0;
        sel = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            sel                     = cy ? s1[k] : s0[k];
            sum[k*BLOCK +: BLOCK]   = sel[BLOCK-1:0];
            cy                      = sel[BLOCK];
        end
    end

    // datapath: slice sums with carry-in 0 then 1, then registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q     <= 1'b0;
            c         <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                s0[k] <= '0;
                s1[k] <= '0;
            end
        end else begin
            if (in_valid && in_ready) sub_q <= sub;
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                if (state == S0)
                    s0[k] <= {1'b0, a_op[k*BLOCK +: BLOCK]} + {1'b0, b_x[k*BLOCK +: BLOCK]};
                if (state == S1)
                    s1[k] <= {1'b0, a_op[k*BLOCK +: BLOCK]} + {1'b0, b_x[k*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
            end
            if (state == SEL) begin
                c         <= sum;
                carry_out <= cy;
                out_valid <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/addsub_carry_select.md
# addsub_carry_select

Parametrised multi-block carry-select adder/subtractor for wide modular-arithmetic datapaths (RSA/ECC operand widths up to several kbit). Each operand is split into NUM_BLOCKS slices of BLOCK bits. Every slice is summed twice, with carry-in 0 and with carry-in 1, over two cycles. A ripple-select pass then assembles the full result. Compared with the fixed-width 3200-bit adder, this block adds a subtract mode, a global carry/borrow output, valid/ready handshakes on both sides, and generic width.

## Interface
Parameters:
- BLOCK, 128, slice width in bits (≥2).
- NUM_BLOCKS, 25, slice count (≥1); operand width W = BLOCK*NUM_BLOCKS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- a  input  W  minuend / first addend.
- b  input  W  subtrahend / second addend.
- sub  input  1  0: c = a+b; 1: c = a−b (two's complement).
- out_valid  output  1  result valid; held until taken.
- out_ready  input  1  consumer accepts result.
- c  output  W  result, mod 2^W.
- carry_out  output  1  carry out of the top slice. In add mode this is the overflow bit. In subtract mode, 1 means no borrow (a ≥ b unsigned).

## Operation
- FSM states and transitions:
  - IDLE → S0 on in_valid && in_ready. sub is always latched at acceptance.
  - S0 → S1 unconditionally. Registers s0[k] = A[k] + B'[k] + 0 (BLOCK+1 bits) for every k.
  - S1 → SEL unconditionally. Registers s1[k] = A[k] + B'[k] + 1.
  - SEL → HOLD. Performs the ripple select and registers c and carry_out; out_valid ← 1.
  - HOLD → IDLE on out_ready. out_valid ← 0 on the same edge.
- Operand B' = sub ? ~b : b.
- Global carry-in g = sub.
- Ripple select: carry k0 = g. For slice k, choose s1[k] if the incoming carry is 1, else s0[k]. c[k] = selected[BLOCK−1:0]; the next carry = selected[BLOCK].
- carry_out is the carry out of slice NUM_BLOCKS−1.
- c and carry_out hold their values from SEL until the next SEL.
- Only one transaction is in flight; there is no pipelining across requests.
- While rst is high: state = IDLE; s0, s1, c = 0; carry_out = 0; out_valid = 0; in_ready = 1 (IDLE); in_valid is ignored.
- Reset asserted mid-operation (any state) aborts the transaction with no output. The first accept is possible on the first rising edge after rst deasserts.
- in_valid arriving while not in IDLE is not accepted; the requester holds it.
- out_ready while out_valid = 0 is ignored.

## Timing
- Accept edge E0. s0 captured at E1, s1 at E2, result and out_valid = 1 after E3.
- Latency is 3 cycles from accept to out_valid.
- With immediate out_ready, the next accept is possible 1 cycle after the result handshake. Throughput is one operation per 5 cycles.
- in_ready is a combinational decode of state == IDLE.
- out_valid, c and carry_out are registered.
- The critical path is one BLOCK+1-bit adder, or the NUM_BLOCKS-deep select mux chain in SEL.

## Configuration
- Macro ADDSUB_OPERAND_REG_EN.
- Defined: a, b and sub are captured into internal registers at E0. S0/S1 use the registered copies, so the requester may change a and b freely after acceptance.
- Not defined: no operand registers (saves 2W flops). The requester must hold a and b stable from E0 through E2. Only sub is latched.
- Timing and latency are identical in both builds.

## Test plan
All scenarios use BLOCK=8, NUM_BLOCKS=4 (W=32) unless noted.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, sub=0 → c=0x00000000, carry_out=1; out_valid rises exactly 3 cycles after accept.
- Subtract with borrow: a=5, b=7, sub=1 → c=0xFFFFFFFE, carry_out=0.
- Subtract without borrow: a=0x12345678, b=0x02345678, sub=1 → c=0x10000000, carry_out=1.
- Back-pressure: hold out_ready=0 for 10 cycles after the result → out_valid stays 1, c stable, in_ready=0 throughout; the result is taken on the first out_ready; in_ready returns 1 the next cycle.
- Reset mid-op: assert rst in S1 → out_valid=0, c=0, in_ready=1. A new request after release (a=1, b=2, sub=0) gives c=3.
- With ADDSUB_OPERAND_REG_EN defined: change a/b to random values one cycle after accept → result still matches the accepted operands. Repeat 1000 random add/sub vectors at the default parameters (BLOCK=128, NUM_BLOCKS=25) against a W-bit reference model.
